// File: rtl/axi_log_drain.sv
// axi_log_drain: reads NumEntries log entries out of the logger BRAM
// (WPE 32-bit words per entry, 16-byte stride), streams them over
// AXI-Stream through a 2-entry skid FIFO, then pulses Clear/Done.
//
// Optional feature: define AXI_LOG_DRAIN_AUTO_EN to start a full-depth
// drain on a rising edge of Full_SI seen in IDLE.
//
// Ports:
//   Clk_CI, Rst_RBI          clock, async active-low reset
//   Start_SI, NumEntries_DI  drain request and entry count (IDLE only)
//   Full_SI                  logger full status
//   Clear_SO, Done_SO        one-cycle completion pulses
//   Busy_SO                  not IDLE
//   BramEn_SO, BramAddr_SO   BRAM read port, BramRd_DI valid one cycle later
//   TData_DO/TValid_SO/TReady_SI/TLast_SO  output stream
module axi_log_drain #(
  parameter int unsigned AXI_ADDR_BITW   = 32,
  parameter int unsigned NUM_LOG_ENTRIES = 16384
) (
  input  logic                               Clk_CI,
  input  logic                               Rst_RBI,
  input  logic                               Start_SI,
  input  logic [$clog2(NUM_LOG_ENTRIES):0]   NumEntries_DI,
  input  logic                               Full_SI,
  output logic                               Clear_SO,
  output logic                               Busy_SO,
  output logic                               Done_SO,
  output logic                               BramEn_SO,
  output logic [$clog2(NUM_LOG_ENTRIES)+3:0] BramAddr_SO,
  input  logic [31:0]                        BramRd_DI,
  output logic [31:0]                        TData_DO,
  output logic                               TValid_SO,
  input  logic                               TReady_SI,
  output logic                               TLast_SO
);
  localparam int unsigned WPE            = (AXI_ADDR_BITW == 32) ? 3 : 4;
  localparam int unsigned CNT_BITW       = $clog2(NUM_LOG_ENTRIES);
  localparam int unsigned BRAM_ADDR_BITW = CNT_BITW + 4;
  localparam int unsigned BEAT_BITW      = CNT_BITW + 3;
  localparam int unsigned DW             = 32;
  localparam logic [CNT_BITW:0] MAX_N    = (CNT_BITW+1)'(NUM_LOG_ENTRIES);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

  state_e                    state_q, state_d;
  logic [CNT_BITW:0]         n_q, n_d, rd_entry_q, rd_entry_d;
  logic [1:0]                rd_word_q, rd_word_d;
  logic [BEAT_BITW-1:0]      beat_q, beat_d, last_q, last_d;
  logic                      en_q, en_d, rvalid_q;
  logic [BRAM_ADDR_BITW-1:0] addr_q, addr_d;
  logic                      busy_q, clear_q, clear_d;
  logic [DW-1:0]             fifo_q [2];
  logic                      wr_ptr_q, rd_ptr_q;
  logic [1:0]                cnt_q, cnt_d;

  logic                      auto_c, go_c, pop_c, push_c, fifo_pop_c, room_c;
  logic                      tvalid_c, tlast_c;
  logic [DW-1:0]             tdata_c;
  logic [CNT_BITW:0]         n_sat_c, n_req_c;

`ifdef AXI_LOG_DRAIN_AUTO_EN
  logic full_q;

  // Edge detector for the logger full flag
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) full_q <= 1'b0;
    else          full_q <= Full_SI;
  end

  assign auto_c = Full_SI && !full_q;
`else
  logic full_unused;
  assign full_unused = Full_SI;
  assign auto_c      = 1'b0;
`endif

  assign n_sat_c = (NumEntries_DI > MAX_N) ? MAX_N : NumEntries_DI;
  assign go_c    = Start_SI || auto_c;
  assign n_req_c = auto_c ? MAX_N : n_sat_c;

  // Stream view: FIFO head if any, else the word arriving from BRAM this cycle
  assign tvalid_c   = (cnt_q != 2'd0) || rvalid_q;
  assign tdata_c    = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : (rvalid_q ? BramRd_DI : '0);
  assign tlast_c    = tvalid_c && (beat_q == last_q);
  assign pop_c      = tvalid_c && TReady_SI;
  assign fifo_pop_c = pop_c && (cnt_q != 2'd0);
  assign push_c     = rvalid_q && !((cnt_q == 2'd0) && pop_c);
  assign cnt_d      = cnt_q + 2'(push_c) - 2'(fifo_pop_c);
  // Reads in flight include the one issued now (en_q) and the one landing now
  assign room_c     = (3'(cnt_q) + 3'(rvalid_q) + 3'(en_q) - 3'(pop_c)) < 3'd2;

  // Next-state and read-issue logic
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    rd_entry_d = rd_entry_q;
    rd_word_d  = rd_word_q;
    beat_d     = beat_q;
    last_d     = last_q;
    en_d       = 1'b0;
    addr_d     = addr_q;
    clear_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go_c) begin
          if (n_req_c == '0) begin
            state_d = CLEAR;
            clear_d = 1'b1;
          end else begin
            // Word 0 of entry 0 is issued on the start edge to meet first-beat latency
            state_d    = DRAIN;
            n_d        = n_req_c;
            last_d     = BEAT_BITW'(n_req_c) * BEAT_BITW'(WPE) - BEAT_BITW'(1);
            beat_d     = '0;
            en_d       = 1'b1;
            addr_d     = '0;
            rd_entry_d = '0;
            rd_word_d  = 2'd1;
          end
        end
      end
      DRAIN: begin
        if ((rd_entry_q != n_q) && room_c) begin
          en_d   = 1'b1;
          addr_d = {rd_entry_q[CNT_BITW-1:0], rd_word_q, 2'b00};
          if (rd_word_q == 2'(WPE-1)) begin
            rd_word_d  = 2'd0;
            rd_entry_d = rd_entry_q + (CNT_BITW+1)'(1);
          end else begin
            rd_word_d  = rd_word_q + 2'd1;
          end
        end
        if (pop_c) begin
          beat_d = beat_q + BEAT_BITW'(1);
          if (tlast_c) begin
            state_d = CLEAR;
            clear_d = 1'b1;
          end
        end
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered control outputs
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q    <= IDLE;
      n_q        <= '0;
      rd_entry_q <= '0;
      rd_word_q  <= '0;
      beat_q     <= '0;
      last_q     <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      rd_entry_q <= rd_entry_d;
      rd_word_q  <= rd_word_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      busy_q     <= (state_d != IDLE);
      clear_q    <= clear_d;
    end
  end

  // Read-data FIFO
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= en_q;
      if (push_c) begin
        fifo_q[wr_ptr_q] <= BramRd_DI;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (fifo_pop_c) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign Clear_SO    = clear_q;
  assign Done_SO     = clear_q;
  assign Busy_SO     = busy_q;
  assign BramEn_SO   = en_q;
  assign BramAddr_SO = addr_q;
  assign TData_DO    = tdata_c;
  assign TValid_SO   = tvalid_c;
  assign TLast_SO    = tlast_c;

endmodule

// File: doc/axi_log_drain.md
AXI_LOG_DRAIN -- requirements
Module: axi_log_drain

Interface
REQ-001 Parameters SHALL be: AXI_ADDR_BITW, default 32, logged address width (32 or 64); NUM_LOG_ENTRIES, default 16384, log depth (power of two, >= 1024).
REQ-002 Derived constants SHALL be: WPE = 3 if AXI_ADDR_BITW=32, else 4 (32-bit words per entry); CNT_BITW = log2(NUM_LOG_ENTRIES); BRAM_ADDR_BITW = CNT_BITW+4 (16-byte entry stride).
REQ-003 Clk_CI  in  1  sole clock, rising edge.
REQ-004 Rst_RBI  in  1  reset; one clock, asynchronous, active-low.
REQ-005 Start_SI  in  1  drain request pulse, sampled in IDLE only.
REQ-006 NumEntries_DI  in  CNT_BITW+1  entries to drain (0..NUM_LOG_ENTRIES), sampled with Start_SI.
REQ-007 Full_SI  in  1  logger full status (logger Full_SO).
REQ-008 Clear_SO  out  1  one-cycle clear pulse to the logger's Clear_SI.
REQ-009 Busy_SO  out  1  high in any state other than IDLE.
REQ-010 Done_SO  out  1  one-cycle completion pulse.
REQ-011 BramEn_SO  out  1  BRAM read enable, 32-bit read port.
REQ-012 BramAddr_SO  out  BRAM_ADDR_BITW  BRAM byte address.
REQ-013 BramRd_DI  in  32  BRAM read data, valid exactly 1 cycle after BramEn_SO.
REQ-014 TData_DO  out  32  stream data; TValid_SO out 1; TReady_SI in 1; TLast_SO out 1.

Function
REQ-015 FSM states SHALL be IDLE, DRAIN, CLEAR; IDLE->DRAIN on Start_SI; DRAIN->CLEAR on acceptance of the word with TLast_SO=1; CLEAR->IDLE after exactly one cycle.
REQ-016 Entry e, word w SHALL be read at BramAddr_SO = e*16 + w*4, in order e=0..N-1, w=0..WPE-1 (timestamp, meta, address low, address high if 64-bit).
REQ-017 Stream SHALL follow AXI-Stream rules: TData/TLast held stable while TValid_SO=1 and TReady_SI=0; transfer when both are high.
REQ-018 TLast_SO SHALL be 1 only on word WPE-1 of entry N-1.
REQ-019 Read data SHALL be buffered in a 2-entry FIFO; a read SHALL issue only if (occupancy + reads in flight - pop this cycle) < 2; no word SHALL be dropped or duplicated.
REQ-020 With TReady_SI held 1, first TValid_SO SHALL rise 2 cycles after the Start_SI cycle, and throughput SHALL be one word per cycle.
REQ-021 Clear_SO and Done_SO SHALL pulse together for exactly the one cycle spent in CLEAR.
REQ-022 NumEntries_DI=0 SHALL go IDLE->CLEAR directly, with no BRAM read and no stream beat.
REQ-023 NumEntries_DI > NUM_LOG_ENTRIES SHALL be saturated to NUM_LOG_ENTRIES.
REQ-024 Start_SI outside IDLE SHALL be ignored.
REQ-025 Word/entry counters SHALL be wide enough that N*WPE does not wrap.

Reset
REQ-026 Asserting Rst_RBI SHALL immediately force IDLE, empty the FIFO, clear counters and in-flight state, and drive every output to 0 (BramAddr_SO=0, TData_DO=0).
REQ-027 Reset asserted mid-drain SHALL abandon the drain without a Clear_SO or Done_SO pulse.

Configuration
REQ-028 With AXI_LOG_DRAIN_AUTO_EN defined, a rising edge of Full_SI seen in IDLE SHALL start a drain of NUM_LOG_ENTRIES entries, as if Start_SI had been asserted.
REQ-029 Without AXI_LOG_DRAIN_AUTO_EN, Full_SI SHALL have no effect and drains SHALL start only on Start_SI.

Verification
REQ-030 32-bit address, Start with N=2, TReady=1 -> 6 beats from addresses 0x00,0x04,0x08,0x10,0x14,0x18; TLast on beat 6; Clear_SO and Done_SO pulse 1 cycle after beat 6.
REQ-031 64-bit address, N=1, TReady toggling 1/0 every cycle -> 4 beats in order, each held stable while stalled, TLast on beat 4.
REQ-032 N=0 -> Busy high 1 cycle, Clear_SO and Done_SO pulse, no BramEn_SO, no TValid_SO.
REQ-033 Reset asserted after beat 3 of an N=4 drain -> all outputs 0 at once, no Clear_SO; a later Start with N=1 restarts at address 0.
REQ-034 AUTO_EN defined, NUM_LOG_ENTRIES=1024, Full_SI rises -> 3072 beats, then Clear_SO; Full_SI held high afterwards causes no second drain.
REQ-035 Start_SI pulsed during DRAIN, NumEntries_DI=20000 with NUM_LOG_ENTRIES=16384 -> pulse ignored; the saturated drain emits exactly 16384*WPE beats.
